mips_cpu_sequencer: RTL
=======================

// Module: mips_cpu_sequencer
// PURPOSE
// Multi-cycle state sequencer for the MIPS CPU; it drives the state encoding
// consumed by mips_cpu_controller. It holds FETCH, DECODE and EXEC states under
// memory waitrequest, sizes each instruction's execute phase by opcode class and
// inserts a parametrised multiply/divide wait phase. It halts after the delay
// slot of a jump to HALT_ADDR.
// PARAMETERS
// ADDR_W         32     width of pc_next / jump target compare
// HALT_ADDR      32'h0  jump target that terminates execution (after delay slot)
// MULDIV_CYCLES  32     extra cycles held in MULDIV_WAIT for MULT/MULTU/DIV/DIVU; 0 = no wait state
// CNT_W          6      muldiv counter width; must hold MULDIV_CYCLES
// PORTS
// clk           in   1      rising-edge clock, only clock
// reset         in   1      synchronous, active-low reset
// opcode        in   6      IR[31:26], valid from DECODE onward
// fncode        in   6      IR[5:0]
// regimm        in   5      IR[20:16]
// waitrequest   in   1      memory not ready this cycle
// jump_taken    in   1      retiring instruction redirects PC (jump or taken branch)
// jump_target   in   ADDR_W target of that redirect
// state         out  3      0 HALTED, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2, 5 MULDIV_WAIT
// active        out  1      1 in every state except HALTED
// stall         out  1      1 when waitrequest holds FETCH or a memory EXEC1
// retire        out  1      1-cycle pulse on the final execute cycle of each instruction
// muldiv_count  out  CNT_W  cycles remaining in MULDIV_WAIT, else 0
// halt_pending  out  1      jump to HALT_ADDR retired; delay slot in flight
// BEHAVIOUR
// - reset==0 at posedge: state=HALTED, active=0, stall=0, retire=0, muldiv_count=0,
//   halt_pending=0. This takes priority over all inputs in every state, including mid-stall.
// - First posedge with reset==1 after reset: HALTED -> FETCH. Thereafter HALTED is absorbing until reset.
// - FETCH: hold while waitrequest=1 (stall=1); otherwise -> DECODE. DECODE -> EXEC1 unconditionally after 1 cycle.
// - Classes, decoded from opcode/fncode/regimm in EXEC1:
//   LOAD  opcode 0x20-0x26: EXEC1 (hold+stall while waitrequest) -> EXEC2 -> next
//   LINKBR opcode 0x01 with regimm[4]=1 (BLTZAL/BGEZAL): EXEC1 -> EXEC2 -> next
//   STORE opcode 0x28,0x29,0x2b: EXEC1 (hold+stall while waitrequest) -> next
//   MULDIV opcode 0 with fncode 0x18-0x1b: EXEC1 -> MULDIV_WAIT (muldiv_count loaded
//     with MULDIV_CYCLES, decrements each cycle, leaves when it reads 1) -> next;
//     MULDIV_CYCLES=0 goes EXEC1 -> next
//   all others, including undefined opcodes: EXEC1 -> next
// - "next" = FETCH, or HALTED if the retiring instruction is the delay slot (halt_pending=1).
// - retire=1 exactly in the cycle that transitions to next; it is never asserted while stall=1.
// - Halt: at retire with jump_taken=1 and jump_target==HALT_ADDR, set halt_pending. The
//   next retire clears it and enters HALTED. A second such jump retiring in the delay
//   slot still halts (no re-arm).
// - Simultaneous: halt_pending and a MULDIV delay slot -> halt only after MULDIV_WAIT completes.
// - waitrequest is ignored in DECODE, EXEC2, MULDIV_WAIT and HALTED.
// - Outputs are registered state/counters; stall and retire are combinational from state
//   and inputs. Minimum instruction latency is 3 cycles (FETCH, DECODE, EXEC1).
// TESTING
// - Reset low 2 cycles, then ADDIU with waitrequest=0 -> states 0,1,2,3,1; retire in the EXEC1 cycle; active=1 from FETCH.
// - LW with waitrequest=1 for 3 cycles in FETCH and 2 in EXEC1 -> FETCH x4, DECODE, EXEC1 x3, EXEC2; stall=1 for 5 cycles.
// - DIV with MULDIV_CYCLES=32 -> 32 cycles in state 5, muldiv_count 32..1, then FETCH; MULDIV_CYCLES=0 -> no state 5.
// - JR retiring with jump_target=0, then ADDIU delay slot -> halt_pending=1 in between; ADDIU retire -> HALTED; stays halted 100 cycles.
// - reset=0 asserted during EXEC1 of SW while waitrequest=1 -> next cycle HALTED, all outputs reset values; restart -> FETCH.
// - BGEZAL (regimm=0x11) -> EXEC1, EXEC2 then FETCH; BGEZ (regimm=0x01) -> EXEC1 then FETCH.

Source files
------------

// File: rtl/mips_cpu_sequencer.sv
// rtl/mips_cpu_sequencer.sv - multi-cycle FETCH/DECODE/EXEC state sequencer for the MIPS CPU
// Sizes each instruction's execute phase by opcode class and halts after the delay slot of a jump to HALT_ADDR.
module mips_cpu_sequencer #(
  parameter int unsigned       ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR     = '0,
  parameter int unsigned       MULDIV_CYCLES = 32,
  parameter int unsigned       CNT_W         = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [5:0]        fncode,
  input  logic [4:0]        regimm,
  input  logic              waitrequest,
  input  logic              jump_taken,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [2:0]        state,
  output logic              active,
  output logic              stall,
  output logic              retire,
  output logic [CNT_W-1:0]  muldiv_count,
  output logic              halt_pending
);

  typedef enum logic [2:0] {
    S_HALTED      = 3'd0,
    S_FETCH       = 3'd1,
    S_DECODE      = 3'd2,
    S_EXEC1       = 3'd3,
    S_EXEC2       = 3'd4,
    S_MULDIV_WAIT = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic             boot_q, boot_d;

  logic is_load, is_store, is_linkbr, is_muldiv, done;
  logic unused_regimm;

  assign unused_regimm = ^regimm[3:0];

  assign is_load   = (opcode >= 6'h20) && (opcode <= 6'h26);
  assign is_store  = (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2b);
  assign is_linkbr = (opcode == 6'h01) && regimm[4];
  assign is_muldiv = (opcode == 6'h00) && (fncode >= 6'h18) && (fncode <= 6'h1b);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    boot_d  = boot_q;
    stall   = 1'b0;
    retire  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_HALTED: begin
        // Only the first cycle out of reset leaves HALTED; a halt by jump is final.
        if (boot_q) begin
          state_d = S_FETCH;
          boot_d  = 1'b0;
        end
      end
      S_FETCH: begin
        if (waitrequest) stall = 1'b1;
        else             state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC1;
      S_EXEC1: begin
        if ((is_load || is_store) && waitrequest) begin
          stall = 1'b1;
        end else if (is_load || is_linkbr) begin
          state_d = S_EXEC2;
        end else if (is_muldiv && (MULDIV_CYCLES != 0)) begin
          state_d = S_MULDIV_WAIT;
          cnt_d   = CNT_W'(MULDIV_CYCLES);
        end else begin
          done = 1'b1;
        end
      end
      S_EXEC2: done = 1'b1;
      S_MULDIV_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d = '0;
          done  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_HALTED;
    endcase

    // The instruction retiring with halt_pending set is the delay slot.
    if (done) begin
      retire = 1'b1;
      if (halt_q) begin
        halt_d  = 1'b0;
        state_d = S_HALTED;
      end else begin
        state_d = S_FETCH;
        if (jump_taken && (jump_target == HALT_ADDR)) halt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_HALTED;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      boot_q  <= boot_d;
    end
  end

  assign state        = state_q;
  assign active       = (state_q != S_HALTED);
  assign muldiv_count = cnt_q;
  assign halt_pending = halt_q;

endmodule
